// File: rtl/mod47_pkg.sv
// Shared mod-47 definitions: modulus, residue width and reducer state encoding.
// Also used by the downstream LUT stages for residue width.
package mod47_pkg;

  localparam int MODULUS   = 47;
  localparam int RES_W     = 6;
  localparam int RADIX_RES = 17;   // 64 mod 47

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [RES_W-1:0] res_t;

endpackage

// File: rtl/mod47_step.sv
// One Horner step of a mod-47 reduction: res = (64*acc + d) mod 47, purely combinational.
// Zero latency; no handshake, the caller owns flow control.
module mod47_step
  import mod47_pkg::*;
(
  input  logic [RES_W-1:0] acc,
  input  logic [5:0]       d,
  output logic [RES_W-1:0] res
);

  // Sized for any 6-bit acc (17*63 + 63 = 1134), not only reduced ones.
  localparam int SUM_W = 11;
  // Reciprocal multiply: ceil(2^16/47) = 1395 gives an exact quotient for sums below 2259.
  localparam int SHIFT = 16;
  localparam int RECIP = 1395;
  localparam int PROD_W = SUM_W + 11;

  logic [SUM_W-1:0] sum;
  logic [4:0]       quot;

  always_comb begin
    sum  = SUM_W'(RADIX_RES) * SUM_W'(acc) + SUM_W'(d);
    quot = 5'((PROD_W'(sum) * PROD_W'(RECIP)) >> SHIFT);
    res  = RES_W'(sum - SUM_W'(quot) * SUM_W'(MODULUS));
  end

endmodule

// File: rtl/mod47_serial_reducer.sv
// Reduces a CHUNKS x 6-bit MSB-first operand to its residue mod 47; residue valid the cycle after the last chunk.
// Holds the residue (in_ready low) until out_ready; one chunk per cycle otherwise.
module mod47_serial_reducer
  import mod47_pkg::*;
#(
  parameter int CHUNKS = 50,
  parameter int CNT_W  = $clog2(CHUNKS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data
);

  state_t           state, state_nxt;
  logic [RES_W-1:0] acc, acc_nxt;
  logic [RES_W-1:0] res_q, res_nxt;
  logic [RES_W-1:0] step_res;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             take;
  logic             last;

  mod47_step u_step (
    .acc (acc),
    .d   (in_data),
    .res (step_res)
  );

  // Outputs decode from state only; rst just masks in_ready during reset.
  assign in_ready  = (state == ACC) && !rst;
  assign out_valid = (state == HOLD);
  assign out_data  = res_q;

  assign take = in_valid && in_ready;
  assign last = (cnt == CNT_W'(CHUNKS - 1));

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    res_nxt   = res_q;
    case (state)
      ACC: begin
        if (take) begin
          if (last) begin
            res_nxt   = step_res;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            acc_nxt = step_res;
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      res_q <= res_nxt;
    end
  end

endmodule

// File: tb/tb_mod47_serial_reducer.sv
// Randomised and directed checks of mod47_serial_reducer against a big-integer mod-47 model.
module tb_mod47_serial_reducer;

  localparam int CHUNKS = 50;
  localparam int OP_W   = 6 * CHUNKS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] in_data = '0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [5:0] out_data;

  logic       c1_in_valid = 1'b0;
  logic [5:0] c1_in_data = '0;
  logic       c1_out_ready = 1'b1;
  logic       c1_in_ready;
  logic       c1_out_valid;
  logic [5:0] c1_out_data;

  always #5 clk = ~clk;

  mod47_serial_reducer #(.CHUNKS(CHUNKS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  mod47_serial_reducer #(.CHUNKS(1)) dut_c1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (c1_in_valid),
    .in_ready  (c1_in_ready),
    .in_data   (c1_in_data),
    .out_valid (c1_out_valid),
    .out_ready (c1_out_ready),
    .out_data  (c1_out_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: frame chunks collected into one big integer, residue by plain % 47.
  bit              started = 1'b0;
  bit              m_hold  = 1'b0;
  int              m_cnt   = 0;
  logic [OP_W-1:0] m_buf   = '0;
  int              m_res   = 0;
  int              got_q[$];

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", int'(in_ready), int'(!m_hold && !rst));
      chk("out_valid", int'(out_valid), int'(m_hold));
      chk("out_data", int'(out_data), m_res);
      if (rst) begin
        m_hold = 1'b0;
        m_cnt  = 0;
        m_buf  = '0;
        m_res  = 0;
      end else if (m_hold) begin
        if (out_ready) begin
          got_q.push_back(int'(out_data));
          m_hold = 1'b0;
        end
      end else if (in_valid) begin
        m_buf = (m_buf << 6) | OP_W'(in_data);
        m_cnt++;
        if (m_cnt == CHUNKS) begin
          m_res  = int'(m_buf % OP_W'(47));
          m_hold = 1'b1;
          m_cnt  = 0;
          m_buf  = '0;
        end
      end
    end
  end

  logic [5:0] frame [CHUNKS];

  function automatic int golden_of_frame();
    logic [OP_W-1:0] op;
    op = '0;
    for (int i = 0; i < CHUNKS; i++) op = (op << 6) | OP_W'(frame[i]);
    return int'(op % OP_W'(47));
  endfunction

  // Entered and left at posedge+1; returns once the chunk has been accepted.
  task automatic drive_chunk(input logic [5:0] d);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL chunk_accept_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int gap_pct);
    for (int i = 0; i < CHUNKS; i++) begin
      for (int g = 0; g < 6 && $urandom_range(0, 99) < gap_pct; g++) begin
        in_valid = 1'b0;
        in_data  = 6'($urandom);
        @(posedge clk); #1;
      end
      drive_chunk(frame[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input int exp);
    int guard;
    guard = 0;
    while (got_q.size() == 0 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (got_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no residue handshake, expected %0d", name, exp);
    end else begin
      chk(name, got_q.pop_front(), exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < CHUNKS; i++) frame[i] = 6'd0;
  endtask

  task automatic random_frame();
    for (int i = 0; i < CHUNKS; i++) frame[i] = 6'($urandom);
  endtask

  task automatic c1_run();
    int vals [4];
    int exps [4];
    vals = '{46, 47, 63, 0};
    exps = '{46, 0, 16, 0};
    c1_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c1_in_valid = 1'b1;
      c1_in_data  = 6'(vals[k]);
      @(negedge clk);
      chk("c1_in_ready", int'(c1_in_ready), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("c1_out_valid", int'(c1_out_valid), 1);
      chk("c1_out_data", int'(c1_out_data), exps[k]);
      chk("c1_hold_ready", int'(c1_in_ready), 0);
      @(posedge clk); #1;
    end
    c1_in_valid = 1'b0;
    @(negedge clk);
    chk("c1_idle_valid", int'(c1_out_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    started = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Operand 1, back-to-back; residue valid the cycle after the last handshake.
    clear_frame();
    frame[CHUNKS-1] = 6'd1;
    send_frame(0);
    chk("latency_valid", int'(out_valid), 1);
    wait_res("op_one", 1);

    // 2^300 - 1
    for (int i = 0; i < CHUNKS; i++) frame[i] = 6'd63;
    send_frame(0);
    wait_res("all_ones", 1);

    clear_frame();
    frame[CHUNKS-2] = 6'd1;
    send_frame(0);
    wait_res("op_64", 17);

    clear_frame();
    frame[CHUNKS-1] = 6'd47;
    send_frame(0);
    wait_res("op_47", 0);

    // Backpressure: residue held for 5 cycles while in_valid stays high.
    random_frame();
    out_ready = 1'b0;
    send_frame(0);
    in_valid = 1'b1;
    repeat (5) begin
      in_data = 6'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_res("backpressure", golden_of_frame());

    for (int f = 0; f < 4; f++) begin
      random_frame();
      send_frame(35);
      wait_res("random_gaps", golden_of_frame());
    end

    // Reset pulse mid-frame aborts it; the following frame starts clean.
    random_frame();
    for (int i = 0; i < 20; i++) drive_chunk(frame[i]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    clear_frame();
    frame[CHUNKS-2] = 6'd1;
    send_frame(0);
    wait_res("after_reset", 17);
    repeat (5) @(posedge clk);
    #1;
    chk("no_extra_residue", got_q.size(), 0);

    c1_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
